// File: rtl/pipeline_propagation_core_pkg.sv
// Shared helpers for the pipeline propagation core: parameter legality used at elaboration.
package pipeline_propagation_core_pkg;

  function automatic logic params_legal(input int data_width, input int pstage);
    logic ok_s;
    if ((data_width >= 1) && (pstage >= 0)) begin
      ok_s = 1'b1;
    end else begin
      ok_s = 1'b0;
    end
    return ok_s;
  endfunction

endpackage

// File: rtl/pipeline_propagation_core_stage_reg.sv
// One DATA_WIDTH delay-line stage: enable-gated load, asynchronous active-low clear to zero.
module pipeline_stage_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;

  // Next value: load on enable, otherwise recirculate (enable is a data mux, not a gated clock).
  always_comb begin
    data_d = data_q;
    if (ce) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipeline_propagation_core.sv
// Register delay line of PSTAGE enable-gated stages; PSTAGE=0 degenerates to a wire.
module pipeline_propagation_core
  import pipeline_propagation_core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PSTAGE     = 3
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_o
);

  if (!params_legal(DATA_WIDTH, PSTAGE)) begin : g_bad_params
    $error("pipeline_propagation_core: DATA_WIDTH must be >= 1 and PSTAGE >= 0");
  end

  if (PSTAGE == 0) begin : g_pass
    // Control inputs are intentionally ignored in the pass-through case.
    logic unused_ctrl_s;
    assign unused_ctrl_s = ^{clk, arst, ce};
    assign data_o = data_in;
  end else begin : g_chain
    logic [DATA_WIDTH-1:0] stage_s [0:PSTAGE];

    assign stage_s[0] = data_in;

    for (genvar i = 1; i <= PSTAGE; i++) begin : g_stage
      pipeline_stage_reg #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_stage (
        .clk  (clk),
        .arst (arst),
        .ce   (ce),
        .d    (stage_s[i-1]),
        .q    (stage_s[i])
      );
    end

    assign data_o = stage_s[PSTAGE];
  end

endmodule

// File: tb/tb_pipeline_propagation_core.sv
// Scoreboard bench: three depths (3, 1, 0) driven in parallel against an enabled-edge history model.
module tb_pipeline_propagation_core;

  logic        clk;
  logic        arst;
  logic        ce;
  logic [31:0] data_in;
  logic [31:0] data_o3;
  logic [31:0] data_o1;
  logic [31:0] data_o0;

  int checks;
  int failures;

  // Inputs accepted on enabled, out-of-reset edges since the last reset.
  logic [31:0] hist[$];
  logic [31:0] exp3[$];
  logic [31:0] exp1[$];

  pipeline_propagation_core #(.DATA_WIDTH(32), .PSTAGE(3)) u_dut3 (
    .clk(clk), .arst(arst), .ce(ce), .data_in(data_in), .data_o(data_o3));
  pipeline_propagation_core #(.DATA_WIDTH(32), .PSTAGE(1)) u_dut1 (
    .clk(clk), .arst(arst), .ce(ce), .data_in(data_in), .data_o(data_o1));
  pipeline_propagation_core #(.DATA_WIDTH(32), .PSTAGE(0)) u_dut0 (
    .clk(clk), .arst(arst), .ce(ce), .data_in(data_in), .data_o(data_o0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model(input int depth);
    logic [31:0] r;
    if (hist.size() >= depth) r = hist[hist.size() - depth];
    else r = 32'h0;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  // One clock cycle: apply inputs, record the edge in the model, queue expected outputs.
  task automatic cyc(input logic [31:0] din, input logic ce_v);
    data_in = din;
    ce = ce_v;
    #1;
    check("p0_passthrough", data_o0, din);
    @(posedge clk);
    if (arst && ce_v) hist.push_back(din);
    exp3.push_back(model(3));
    exp1.push_back(model(1));
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare registered outputs on the falling edge after each rising edge.
  always @(negedge clk) begin
    if (exp3.size() > 0) check("p3_data", data_o3, exp3.pop_front());
    if (exp1.size() > 0) check("p1_data", data_o1, exp1.pop_front());
  end

  initial begin
    logic [31:0] r;
    checks = 0;
    failures = 0;
    arst = 1'b0;
    ce = 1'b1;
    data_in = 32'h0;
    #1;
    check("reset_before_edge_p3", data_o3, 32'h0);
    check("reset_before_edge_p1", data_o1, 32'h0);

    // Held in reset with the clock running and ce=1.
    for (int i = 0; i < 10; i++) cyc(32'h0, 1'b1);
    // Inputs presented during reset must be ignored.
    cyc(32'hDEADBEEF, 1'b1);

    // Ramp 1..10 then flush.
    arst = 1'b1;
    for (int i = 1; i <= 10; i++) cyc(32'(i), 1'b1);
    for (int i = 0; i < 4; i++) cyc(32'h0, 1'b1);

    // Clock-enable gap mid-stream.
    cyc(32'h11, 1'b1);
    cyc(32'h22, 1'b1);
    cyc(32'h99, 1'b0);
    cyc(32'h77, 1'b0);
    cyc(32'h33, 1'b1);
    cyc(32'h44, 1'b1);
    for (int i = 0; i < 4; i++) cyc(32'h0, 1'b1);

    // Mid-stream asynchronous reset between edges.
    cyc(32'hA, 1'b1);
    cyc(32'hB, 1'b1);
    cyc(32'hC, 1'b1);
    arst = 1'b0;
    #1;
    check("async_clear_p3", data_o3, 32'h0);
    check("async_clear_p1", data_o1, 32'h0);
    hist.delete();
    #1;
    arst = 1'b1;
    cyc(32'h5, 1'b1);
    for (int i = 0; i < 4; i++) cyc(32'h0, 1'b1);

    // Width edge values.
    cyc(32'hFFFFFFFF, 1'b1);
    cyc(32'h80000001, 1'b1);
    for (int i = 0; i < 4; i++) cyc(32'h0, 1'b1);

    // Randomised data and enable.
    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      cyc(r, ($urandom_range(0, 3) != 0));
    end

    // Pass-through is independent of ce and arst.
    ce = 1'b0;
    arst = 1'b0;
    data_in = 32'h1234;
    #1;
    check("p0_in_reset", data_o0, 32'h1234);
    check("p3_in_reset", data_o3, 32'h0);
    hist.delete();
    @(negedge clk);
    #1;
    arst = 1'b1;

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp3.size() + exp1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_propagation_core.md
Name: pipeline_propagation_core

Overview:
Parameterisable register delay line for a data word of configurable width. The word propagates through PSTAGE registered stages under a common clock enable. It is used in the trigger-consolidation datapath for timing closure and for latency alignment between parallel paths. Pure datapath: no handshake, no valid tagging.

Parameters:
DATA_WIDTH, 32, bit width of data_in, data_o and every stage register; legal range is 1 or more.
PSTAGE, 3, number of register stages (latency in enabled clock edges); legal range is 0 or more; 0 gives a combinational pass-through.

Ports:
clk  input  1  single clock; all stage registers update on the rising edge.
arst  input  1  reset, asynchronous, active-low; 0 clears all stages immediately, with no clock needed.
ce  input  1  clock enable, active-high; 0 holds every stage register.
data_in  input  DATA_WIDTH  word entering stage 1.
data_o  output  DATA_WIDTH  output of the last stage (stage PSTAGE).

Behaviour:
- Stage registers are s[1..PSTAGE], each DATA_WIDTH bits wide; data_o = s[PSTAGE].
- Reset:
  - While arst=0, every s[i] is 0, so data_o is 0.
  - Assertion clears asynchronously, mid-operation included; all in-flight words are discarded.
  - After deassertion, the first update happens on the first rising edge with arst=1 and ce=1.
- On a rising clk edge with arst=1 and ce=1: s[1] <= data_in and s[i] <= s[i-1] for i=2..PSTAGE, all updating together (shift).
- On a rising clk edge with ce=0: all stages hold; nothing is lost or duplicated. Latency counts enabled edges only.
- Latency: the word sampled on enabled edge n appears on data_o right after enabled edge n+PSTAGE-1. Equivalently, data_o equals data_in as sampled PSTAGE enabled edges earlier.
- With ce held at 1, data_o(k) = data_in(k-PSTAGE) in cycles. For the first PSTAGE enabled edges after reset, data_o shows the reset value 0.
- PSTAGE=0:
  - data_o = data_in combinationally.
  - ce, clk and arst have no effect on data_o.
  - No registers are inferred.
- PSTAGE=1: a single enable-gated register.
- Data is not interpreted: no arithmetic, full-width copy, no truncation or extension.
- No X propagation out of reset: every stage has a defined reset value.
- Reset values are 0 for all bits; there is no programmable reset value.
- Implementation uses a generate over stages. Synthesis tools may retime; the stages must not be merged or removed by design intent. The enable is applied per stage, not as clock gating.

Decomposition:
- No shared package is required. DATA_WIDTH and PSTAGE remain module parameters; any default-latency constant is owned by the integrating module.
- One natural sub-module: pipeline_stage_reg. It is a DATA_WIDTH register with clk, arst (async, active-low, clear to 0), ce, d and q. It is instantiated PSTAGE times in a generate chain; a generate-if selects the PSTAGE=0 pass-through.
- The top is only chaining and parameter legality checks: elaboration error if DATA_WIDTH<1 or PSTAGE<0.

Test Plan:
1. Reset: DATA_WIDTH=32, PSTAGE=3, ce=1, arst=0 for 10 cycles with data_in=0x0 -> data_o=0x00000000 throughout, including before the first clock edge.
2. Ramp: release arst, then increment data_in 1..10 one per rising edge, ce=1 -> data_o shows 0,0,0 then 0x1..0xA, each value appearing exactly 3 enabled edges after it was presented.
3. Clock enable: PSTAGE=3, stream 0x11,0x22,0x33,0x44, with ce dropped to 0 for 2 cycles mid-stream -> data_o frozen during those cycles; the sequence resumes with no loss or duplication; total latency is 3 enabled edges.
4. Mid-stream reset: PSTAGE=3 with stages holding 0xA,0xB,0xC; pulse arst=0 between edges -> data_o becomes 0 immediately, without a clock. After release, new input 0x5 appears 3 enabled edges later and the old data never reappears.
5. Width and edge values: DATA_WIDTH=32, data_in=0xFFFFFFFF then 0x80000001 -> appear bit-exact on data_o after 3 edges.
6. Degenerate depths: PSTAGE=1 -> data_o = data_in delayed 1 edge. PSTAGE=0 -> data_o tracks data_in combinationally (e.g. 0x1234 shows within the same delta), independent of ce and arst.
